// File: rtl/conv3x3_tap_sequencer.sv
// Sequential 3x3 convolution: one DW x DW multiplier is stepped over the nine
// taps of a window, products are summed into an ACCW-bit result.
module conv3x3_tap_sequencer #(
  parameter int DW   = 8,
  parameter int ACCW = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_k,
  input  logic              abort,
  input  logic [9*DW-1:0]   x_flat,
  input  logic [9*DW-1:0]   k_flat,
  output logic              busy,
  output logic              done,
  output logic [ACCW-1:0]   result,
  output logic [3:0]        tap_idx
);

  typedef enum logic [1:0] {IDLE, MAC, DRAIN} state_t;

  state_t            state_reg, state_next;
  logic [DW-1:0]     x_reg [9];
  logic [DW-1:0]     k_reg [9];
  logic [2*DW-1:0]   prod_reg;
  logic [ACCW-1:0]   acc_reg;
  logic [ACCW-1:0]   result_reg;
  logic [3:0]        tap_reg;
  logic              busy_reg;
  logic              done_reg;

  logic              accept;
  logic              step;
  logic              finish;
  logic              cancel;
  logic [3:0]        k_idx;
  logic [DW-1:0]     x_sel;
  logic [DW-1:0]     k_sel;
  logic [2*DW-1:0]   prod_next;
  logic [ACCW-1:0]   prod_ext;

  // Kernel is flipped: tap n pairs pixel n with coefficient 8-n.
  assign k_idx     = 4'd8 - tap_reg;
  assign x_sel     = x_reg[tap_reg];
  assign k_sel     = k_reg[k_idx];
  assign prod_next = {{DW{1'b0}}, x_sel} * {{DW{1'b0}}, k_sel};
  assign prod_ext  = {{(ACCW-2*DW){1'b0}}, prod_reg};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    cancel     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          accept     = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        if (abort) begin
          cancel     = 1'b1;
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (tap_reg == 4'd8) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          cancel = 1'b1;
        end else begin
          finish = 1'b1;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture; the kernel is only overwritten when load_k accompanies start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 9; i++) begin
        x_reg[i] <= '0;
        k_reg[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < 9; i++) begin
        x_reg[i] <= x_flat[i*DW +: DW];
        if (load_k) begin
          k_reg[i] <= k_flat[i*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_reg   <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      tap_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        acc_reg  <= '0;
        tap_reg  <= '0;
        busy_reg <= 1'b1;
      end
      if (step) begin
        prod_reg <= prod_next;
        // The first issued tap has no earlier product to fold in.
        if (tap_reg != 4'd0) begin
          acc_reg <= acc_reg + prod_ext;
        end
        if (tap_reg != 4'd8) begin
          tap_reg <= tap_reg + 4'd1;
        end
      end
      if (finish) begin
        result_reg <= acc_reg + prod_ext;
        done_reg   <= 1'b1;
        busy_reg   <= 1'b0;
        tap_reg    <= '0;
      end
      if (cancel) begin
        busy_reg <= 1'b0;
        tap_reg  <= '0;
      end
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign result  = result_reg;
  assign tap_idx = tap_reg;

endmodule

// File: doc/conv3x3_tap_sequencer.md
Name: conv3x3_tap_sequencer

Overview:
- Sequential 3x3 convolution engine.
- Time-multiplexes one DW x DW multiplier over the 9 taps of a window and accumulates the products into a 20-bit result.
- Replaces the fully parallel nine-multiplier window datapath where area matters.
- Uses the same start/done/result contract as the existing multiplier and convolution blocks.
- Kernel coefficients can be retained across windows so a host can stream windows against a fixed kernel.

Parameters:
- DW, 8, operand width of each pixel and kernel coefficient (unsigned).
- ACCW, 20, accumulator/result width; must satisfy ACCW >= 2*DW+4.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to process the window on x_flat; sampled only in IDLE.
- load_k  input  1  when high with an accepted start, capture k_flat into the kernel register; otherwise reuse the stored kernel.
- abort  input  1  synchronous cancel of an operation in progress.
- x_flat  input  9*DW  window pixels, row-major: x11 at [DW-1:0], x12 next, ..., x33 at top.
- k_flat  input  9*DW  kernel coefficients, same packing (k11 lowest).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result is updated.
- result  output  ACCW  convolution sum; holds until the next done.
- tap_idx  output  4  current tap being issued (0..8), 0 when idle; debug.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; busy, done, result, tap_idx, accumulator, product register and kernel register all cleared to 0.
- Arithmetic:
  - result = sum over i,j in 0..2 of k[2-i][2-j]*x[i][j]. The kernel is flipped: true convolution, not correlation.
  - Tap n (n=0..8) maps to x index n and k index 8-n in row-major order.
  - All arithmetic is unsigned. Products are zero-extended to ACCW.
  - Maximum sum at DW=8 is 585225, so no overflow is possible and no saturation logic is included.
- States: IDLE, MAC, DRAIN.
- IDLE:
  - On start=1, at edge E0: capture x_flat; if load_k=1, also capture k_flat.
  - Same edge: clear accumulator, set tap_idx=0, busy<=1, go to MAC.
- MAC, edges E1..E9:
  - Each edge registers product x[tap]*k[8-tap] and increments tap_idx.
  - The accumulator adds the previously registered product on E2..E9.
  - At E9 (tap 8 issued), go to DRAIN.
- DRAIN, edge E10:
  - result <= acc + last product; done<=1; busy<=0; tap_idx<=0; go to IDLE.
- Latency: done is high in the cycle after E10, i.e. 10 clocks after start is sampled. Throughput is one window per 10 clocks.
- done is high for exactly one cycle.
- start while busy=1 is ignored and never queued.
- start in the cycle done is high is accepted, because the block is already in IDLE.
- x_flat/k_flat may change freely after E0; operands are registered.
- load_k=0 on the first start after reset uses an all-zero kernel, giving result 0.
- abort=1 while busy:
  - Return to IDLE at the next edge; busy<=0; no done pulse.
  - result keeps its prior value; the kernel register is retained.
- abort in IDLE has no effect; abort has priority over start in the same cycle.
- reset asserted mid-operation: immediate return to the reset state; no done pulse follows.

Test Plan:
- Reset then start with load_k=1, all x=255, all k=255 -> done exactly 10 clocks after the start edge, result=0x8EE09 (585225), busy high for 10 cycles.
- Flip check: x11..x33=1..9, k11=1 and all other k=0 -> result=9. Then k33=1 only -> result=1.
- Kernel reuse: load kernel of all 1s with x=1..9 (result 45); next start with load_k=0, k_flat=0xFF.., x all 2 -> result 18.
- Back-to-back: assert start in the done cycle with new operands -> second done exactly 10 clocks later with the correct sum. A start pulse mid-operation is ignored (only one done).
- abort asserted at tap_idx=4 -> busy drops next cycle, no done, result unchanged from the previous value. A subsequent start completes normally.
- Async reset pulsed low at tap_idx=6 -> outputs and kernel zero immediately with no clock edge required; no done afterwards; the next start with load_k=0 gives result 0.
